// File: rtl/wb_pkg.sv
// ============================================================================
// wb_pkg: shared widths and types for the writeback / register file slice.
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [DATA_SIZE-1:0]  word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/wb_reg_array.sv
// ============================================================================
// wb_reg_array: register storage with async clear, one write port and two raw read ports.
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_reg_array
  import wb_pkg::*;
#(
  parameter int DATA_SIZE = wb_pkg::DATA_SIZE,
  parameter int NUM_REGS  = wb_pkg::NUM_REGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  reg_addr_t            waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  reg_addr_t            raddr1,
  input  reg_addr_t            raddr2,
  output logic [DATA_SIZE-1:0] rdata1,
  output logic [DATA_SIZE-1:0] rdata2
);

  logic [DATA_SIZE-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata1 = r_mem[raddr1];
  assign rdata2 = r_mem[raddr2];

endmodule

`default_nettype wire

// File: rtl/wb_regfile_unit.sv
// ============================================================================
// wb_regfile_unit: writeback mux, register file commit with write-through reads,
// retired-write counter. Optional pending-write scoreboard under WB_SCOREBOARD_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_regfile_unit
  import wb_pkg::*;
#(
  parameter int DATA_SIZE = wb_pkg::DATA_SIZE,
  parameter int NUM_REGS  = wb_pkg::NUM_REGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 WB_MemtoReg,
  input  logic                 WB_RegWrite,
  input  logic [DATA_SIZE-1:0] WB_DM_Read_Data,
  input  logic [DATA_SIZE-1:0] WB_WD_out,
  input  reg_addr_t            WB_WR_out,
  input  reg_addr_t            Read_addr1,
  input  reg_addr_t            Read_addr2,
  output logic [DATA_SIZE-1:0] Read_data1,
  output logic [DATA_SIZE-1:0] Read_data2,
  output logic [DATA_SIZE-1:0] WB_Write_Data,
`ifdef WB_SCOREBOARD_EN
  input  logic                 ID_Issue,
  input  reg_addr_t            ID_Issue_WR,
  output logic                 Busy1,
  output logic                 Busy2,
`endif
  output logic [31:0]          Retire_Count
);

  logic                 w_eff_wr;
  logic [DATA_SIZE-1:0] w_raw1;
  logic [DATA_SIZE-1:0] w_raw2;
  logic [31:0]          r_retire_count;

  assign WB_Write_Data = WB_MemtoReg ? WB_DM_Read_Data : WB_WD_out;

  // Qualified by rst so reads and busy flags stay quiet while reset is held.
  assign w_eff_wr = rst && WB_RegWrite && (WB_WR_out != REG_ZERO);

  wb_reg_array #(
    .DATA_SIZE (DATA_SIZE),
    .NUM_REGS  (NUM_REGS)
  ) u_reg_array (
    .clk    (clk),
    .rst    (rst),
    .we     (w_eff_wr),
    .waddr  (WB_WR_out),
    .wdata  (WB_Write_Data),
    .raddr1 (Read_addr1),
    .raddr2 (Read_addr2),
    .rdata1 (w_raw1),
    .rdata2 (w_raw2)
  );

  always_comb begin
    Read_data1 = w_raw1;
    if (!rst || Read_addr1 == REG_ZERO) begin
      Read_data1 = '0;
    end else if (w_eff_wr && Read_addr1 == WB_WR_out) begin
      Read_data1 = WB_Write_Data;
    end
  end

  always_comb begin
    Read_data2 = w_raw2;
    if (!rst || Read_addr2 == REG_ZERO) begin
      Read_data2 = '0;
    end else if (w_eff_wr && Read_addr2 == WB_WR_out) begin
      Read_data2 = WB_Write_Data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retire_count <= '0;
    end else if (w_eff_wr) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign Retire_Count = r_retire_count;

`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_sb;
  logic [NUM_REGS-1:0] w_sb_next;

  // Issue set is applied after writeback clear so a same-register collision stays pending.
  always_comb begin
    w_sb_next = r_sb;
    if (w_eff_wr) begin
      w_sb_next[WB_WR_out] = 1'b0;
    end
    if (ID_Issue && ID_Issue_WR != REG_ZERO) begin
      w_sb_next[ID_Issue_WR] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_next;
    end
  end

  assign Busy1 = (Read_addr1 != REG_ZERO) && r_sb[Read_addr1] &&
                 !(w_eff_wr && WB_WR_out == Read_addr1);
  assign Busy2 = (Read_addr2 != REG_ZERO) && r_sb[Read_addr2] &&
                 !(w_eff_wr && WB_WR_out == Read_addr2);
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile_unit.sv
// ============================================================================
// tb_wb_regfile_unit: directed self-checking bench for wb_regfile_unit.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile_unit;

  logic        clk;
  logic        rst;
  logic        mem_to_reg;
  logic        reg_write;
  logic [31:0] dm_data;
  logic [31:0] wd_data;
  logic [4:0]  wr_addr;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] wb_data;
  logic [31:0] retire;
`ifdef WB_SCOREBOARD_EN
  logic        issue;
  logic [4:0]  issue_wr;
  logic        busy1;
  logic        busy2;
`endif

  int checks = 0;
  int errors = 0;

  wb_regfile_unit dut (
    .clk             (clk),
    .rst             (rst),
    .WB_MemtoReg     (mem_to_reg),
    .WB_RegWrite     (reg_write),
    .WB_DM_Read_Data (dm_data),
    .WB_WD_out       (wd_data),
    .WB_WR_out       (wr_addr),
    .Read_addr1      (ra1),
    .Read_addr2      (ra2),
    .Read_data1      (rd1),
    .Read_data2      (rd2),
    .WB_Write_Data   (wb_data),
`ifdef WB_SCOREBOARD_EN
    .ID_Issue        (issue),
    .ID_Issue_WR     (issue_wr),
    .Busy1           (busy1),
    .Busy2           (busy2),
`endif
    .Retire_Count    (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a writeback beat at the falling edge, leaving settle time before the next rise.
  task automatic drive_wb(input logic rw, input logic m2r, input logic [4:0] wr,
                          input logic [31:0] wd, input logic [31:0] dm,
                          input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    reg_write  = rw;
    mem_to_reg = m2r;
    wr_addr    = wr;
    wd_data    = wd;
    dm_data    = dm;
    ra1        = a1;
    ra2        = a2;
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    dm_data    = '0;
    wd_data    = '0;
    wr_addr    = '0;
    ra1        = '0;
    ra2        = '0;
`ifdef WB_SCOREBOARD_EN
    issue      = 1'b0;
    issue_wr   = '0;
`endif

    // Reset held with random traffic: reads and counter stay at zero.
    for (int i = 0; i < 4; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(1, 31));
      drive_wb(1'b1, 1'($urandom), a, $urandom, $urandom, a, 5'($urandom));
      check("rst_rd1", rd1, 32'h0);
      check("rst_rd2", rd2, 32'h0);
      check("rst_retire", retire, 32'h0);
    end

    drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd6);
    rst = 1'b1;
    #1;
    check("post_rst_rd1", rd1, 32'h0);

    // Write-through of an ALU result, then committed value after the edge.
    drive_wb(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h00000055, 5'd5, 5'd6);
    check("bypass_rd1", rd1, 32'hDEADBEEF);
    check("bypass_rd2_other", rd2, 32'h0);
    check("wb_mux_alu", wb_data, 32'hDEADBEEF);
    check("retire_before", retire, 32'h0);
    drive_wb(1'b0, 1'b0, 5'd5, 32'h0, 32'h0, 5'd5, 5'd6);
    check("commit_rd1", rd1, 32'hDEADBEEF);
    check("retire_1", retire, 32'd1);

    // Memory data path, both ports bypassing the same register.
    drive_wb(1'b1, 1'b1, 5'd6, 32'h11111111, 32'hCAFE0001, 5'd6, 5'd6);
    check("wb_mux_mem", wb_data, 32'hCAFE0001);
    check("dual_bypass_rd1", rd1, 32'hCAFE0001);
    check("dual_bypass_rd2", rd2, 32'hCAFE0001);

    // Write to register 0 is dropped and not counted.
    drive_wb(1'b1, 1'b1, 5'd0, 32'h0, 32'h00001234, 5'd0, 5'd5);
    check("r0_wb_data", wb_data, 32'h00001234);
    check("r0_rd1", rd1, 32'h0);
    check("r0_rd2_no_bypass", rd2, 32'hDEADBEEF);
    check("retire_2", retire, 32'd2);
    drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd6);
    check("r0_after_rd1", rd1, 32'h0);
    check("r6_commit", rd2, 32'hCAFE0001);
    check("retire_unchanged", retire, 32'd2);

    // Counter wrap.
    @(negedge clk);
    force dut.r_retire_count = 32'hFFFFFFFF;
    #1;
    release dut.r_retire_count;
    #1;
    check("retire_preload", retire, 32'hFFFFFFFF);
    drive_wb(1'b1, 1'b0, 5'd3, 32'h00000033, 32'h0, 5'd3, 5'd9);
    drive_wb(1'b1, 1'b0, 5'd9, 32'h00000099, 32'h0, 5'd3, 5'd9);
    check("retire_wrap", retire, 32'd0);
    check("r3_commit", rd1, 32'h00000033);
    drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd9);
    check("retire_after_wrap", retire, 32'd1);
    check("r9_commit", rd2, 32'h00000099);

    // Asynchronous reset between edges clears state immediately.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_r3", rd1, 32'h0);
    check("async_rst_r9", rd2, 32'h0);
    check("async_rst_retire", retire, 32'h0);

    // First edge after release commits.
    drive_wb(1'b1, 1'b0, 5'd4, 32'h00000044, 32'h0, 5'd3, 5'd4);
    rst = 1'b1;
    #1;
    check("release_bypass", rd2, 32'h00000044);
    drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd4);
    check("release_r3_clear", rd1, 32'h0);
    check("release_commit_r4", rd2, 32'h00000044);
    check("release_retire", retire, 32'd1);

`ifdef WB_SCOREBOARD_EN
    drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0);
    issue    = 1'b1;
    issue_wr = 5'd7;
    #1;
    check("sb_busy_before", 32'(busy1), 32'd0);
    drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0);
    issue = 1'b0;
    #1;
    check("sb_busy_set", 32'(busy1), 32'd1);
    check("sb_busy_r0", 32'(busy2), 32'd0);
    drive_wb(1'b1, 1'b0, 5'd7, 32'h00000077, 32'h0, 5'd7, 5'd7);
    check("sb_busy_wb_bypass", 32'(busy1), 32'd0);
    drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7);
    check("sb_busy_cleared", 32'(busy2), 32'd0);
    drive_wb(1'b1, 1'b0, 5'd7, 32'h00000078, 32'h0, 5'd7, 5'd8);
    issue    = 1'b1;
    issue_wr = 5'd7;
    #1;
    drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd8);
    issue = 1'b0;
    #1;
    check("sb_set_wins", 32'(busy1), 32'd1);
    check("sb_other_idle", 32'(busy2), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
